// File: rtl/ay3891x_bus_master.sv
// ay3891x_bus_master
// Queues AY-3-8910/8912 register read/write requests and replays them as
// latch-address-then-data tick sequences on the PSG register port.
//   clk, reset                : system clock, synchronous active-high reset
//   req_valid/req_ready       : request handshake into the FIFO
//   req_rd, req_addr, req_data: request contents (data ignored for reads)
//   rsp_valid, rsp_data       : one-cycle read strobe, data held until next
//   busy                      : FIFO non-empty or transaction in flight
//   psg_a0, psg_wr_tick, psg_wdata, psg_rd_tick, psg_rdata : PSG side
module ay3891x_bus_master #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       psg_a0,
  output logic       psg_wr_tick,
  output logic [7:0] psg_wdata,
  output logic       psg_rd_tick,
  input  logic [7:0] psg_rdata
);

  localparam int unsigned   AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW       = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam bit            HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [7:0]    GAP_LOAD = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef struct packed {
    logic       rd;
    logic [3:0] addr;
    logic [7:0] data;
  } req_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RDTICK,
    RDCAP,
    GAP
  } state_t;

  req_t          fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  state_t        state_q;
  req_t          cur_q;
  logic [7:0]    gap_q;

  logic          push;
  logic          pop;
  logic          at_end;
  req_t          head;

  always_comb begin
    req_ready = (count_q < DEPTH_C);
    busy      = (count_q != '0) || (state_q != IDLE);
    push      = req_valid && req_ready;
    head      = fifo_q[rptr_q];

    // A new transaction may start from IDLE or directly out of the last
    // cycle of the previous one, so back-to-back requests need no bubble.
    case (state_q)
      IDLE:         at_end = 1'b1;
      WDATA, RDCAP: at_end = !HAS_GAP;
      GAP:          at_end = (gap_q == '0);
      default:      at_end = 1'b0;
    endcase
    pop = at_end && (count_q != '0);

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= {req_rd, req_addr, req_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Outputs are registered for the state being entered, so the edge that
  // moves into a state also presents that state's bus values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      gap_q       <= '0;
      psg_a0      <= 1'b0;
      psg_wr_tick <= 1'b0;
      psg_rd_tick <= 1'b0;
      psg_wdata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
    end else begin
      psg_a0      <= 1'b0;
      psg_wr_tick <= 1'b0;
      psg_rd_tick <= 1'b0;
      psg_wdata   <= '0;
      rsp_valid   <= 1'b0;

      case (state_q)
        IDLE: state_q <= IDLE;
        ADDR: begin
          psg_a0 <= 1'b1;
          if (cur_q.rd) begin
            state_q     <= RDTICK;
            psg_rd_tick <= 1'b1;
          end else begin
            state_q     <= WDATA;
            psg_wr_tick <= 1'b1;
            psg_wdata   <= cur_q.data;
          end
        end
        WDATA: begin
          state_q <= HAS_GAP ? GAP : IDLE;
          gap_q   <= GAP_LOAD;
        end
        RDTICK: state_q <= RDCAP;
        RDCAP: begin
          rsp_valid <= 1'b1;
          rsp_data  <= psg_rdata;
          state_q   <= HAS_GAP ? GAP : IDLE;
          gap_q     <= GAP_LOAD;
        end
        GAP: begin
          if (gap_q == '0) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Dispatch overrides the per-state next state; the RDCAP capture
      // above still lands because it targets different registers.
      if (pop) begin
        state_q     <= ADDR;
        cur_q       <= head;
        psg_a0      <= 1'b0;
        psg_wr_tick <= 1'b1;
        psg_wdata   <= {4'b0000, head.addr};
      end
    end
  end

endmodule
